// File: rtl/adder8_pkg.sv
// Shared types and helpers for the adder8 result path.
package adder8_pkg;

  // One adder result is {cout, sum}. The adder fixes this width.
  localparam int SMP_W        = 9;
  localparam int WIN_LOG2_DEF = 3;

  typedef logic [SMP_W-1:0] smp_t;

  // Controls for the running min/max registers.
  typedef enum logic [1:0] {
    MM_HOLD   = 2'd0,
    MM_SEED   = 2'd1,
    MM_UPDATE = 2'd2
  } mm_op_e;

  function automatic smp_t max9(input smp_t a, input smp_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic smp_t min9(input smp_t a, input smp_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/adder8_minmax.sv
// Running max/min of a sample window. A seed restarts both extremes from
// the incoming sample, so no compare is ever made against the previous window.
module adder8_minmax
  import adder8_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  mm_op_e i_op,
  input  smp_t   i_v,
  output smp_t   o_max,
  output smp_t   o_min,
  output smp_t   o_max_nxt,
  output smp_t   o_min_nxt
);

  smp_t r_max, r_min;
  smp_t w_max_nxt, w_min_nxt;

  // Next extremes; exposed so the window's last sample can be folded in
  // the same cycle it arrives.
  always_comb begin
    w_max_nxt = r_max;
    w_min_nxt = r_min;
    case (i_op)
      MM_SEED: begin
        w_max_nxt = i_v;
        w_min_nxt = i_v;
      end
      MM_UPDATE: begin
        w_max_nxt = max9(r_max, i_v);
        w_min_nxt = min9(r_min, i_v);
      end
      default: ;
    endcase
  end

  // Running extremes register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_max <= '0;
      r_min <= '0;
    end else begin
      r_max <= w_max_nxt;
      r_min <= w_min_nxt;
    end
  end

  assign o_max     = r_max;
  assign o_min     = r_min;
  assign o_max_nxt = w_max_nxt;
  assign o_min_nxt = w_min_nxt;

endmodule

// File: rtl/adder8_result_accum.sv
// Collects adder results into windows of 2**WIN_LOG2 valid samples and
// publishes sum, truncated average, max, min and carry count with a
// one-cycle out_valid pulse. No backpressure: every valid sample is taken.
module adder8_result_accum #(
  parameter int WIN_LOG2 = adder8_pkg::WIN_LOG2_DEF,
  parameter int SMP_W    = adder8_pkg::SMP_W,
  parameter int ACC_W    = SMP_W + WIN_LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic                cout,
  input  logic [7:0]          sum,
  input  logic                clear,
  output logic                out_valid,
  output logic [ACC_W-1:0]    acc,
  output logic [SMP_W-1:0]    avg,
  output logic [SMP_W-1:0]    max_val,
  output logic [SMP_W-1:0]    min_val,
  output logic [WIN_LOG2:0]   carry_cnt
);
  import adder8_pkg::*;

  localparam int CC_W = WIN_LOG2 + 1;
  localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;  // N-1

  // Window state: number of samples already held.
  logic [WIN_LOG2-1:0] r_cnt;
  logic [ACC_W-1:0]    r_acc;
  logic [CC_W-1:0]     r_cc;

  logic                r_out_valid;
  logic [ACC_W-1:0]    r_acc_out;
  logic [SMP_W-1:0]    r_avg_out;
  logic [SMP_W-1:0]    r_max_out;
  logic [SMP_W-1:0]    r_min_out;
  logic [CC_W-1:0]     r_cc_out;

  smp_t                w_v;
  logic                w_take;
  logic                w_first;
  logic                w_last;
  mm_op_e              w_mm_op;
  logic [ACC_W-1:0]    w_acc_nxt;
  logic [CC_W-1:0]     w_cc_nxt;
  smp_t                w_max, w_min, w_max_nxt, w_min_nxt;

  // clear beats a coincident sample; sum/cout are don't-care without in_valid.
  assign w_v     = {cout, sum};
  assign w_take  = in_valid && !clear;
  assign w_first = w_take && (r_cnt == '0);
  assign w_last  = w_take && (r_cnt == CNT_LAST);

  // Running sum / carry count including the current sample; the first
  // sample of a window re-seeds rather than accumulates.
  always_comb begin
    w_acc_nxt = r_acc;
    w_cc_nxt  = r_cc;
    w_mm_op   = MM_HOLD;
    if (w_first) begin
      w_acc_nxt = ACC_W'(w_v);
      w_cc_nxt  = CC_W'(cout);
      w_mm_op   = MM_SEED;
    end else if (w_take) begin
      w_acc_nxt = r_acc + ACC_W'(w_v);
      w_cc_nxt  = r_cc + CC_W'(cout);
      w_mm_op   = MM_UPDATE;
    end
  end

  adder8_minmax u_minmax (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_op      (w_mm_op),
    .i_v       (w_v),
    .o_max     (w_max),
    .o_min     (w_min),
    .o_max_nxt (w_max_nxt),
    .o_min_nxt (w_min_nxt)
  );

  // Sample counter; wraps to 0 after the last sample, clear restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n)      r_cnt <= '0;
    else if (clear)  r_cnt <= '0;
    else if (in_valid) r_cnt <= r_cnt + 1'b1;
  end

  // Running accumulator and carry count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cc  <= '0;
    end else begin
      r_acc <= w_acc_nxt;
      r_cc  <= w_cc_nxt;
    end
  end

  // Result registers: load on the window's last sample, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_acc_out   <= '0;
      r_avg_out   <= '0;
      r_max_out   <= '0;
      r_min_out   <= '0;
      r_cc_out    <= '0;
    end else begin
      r_out_valid <= w_last;
      if (w_last) begin
        r_acc_out <= w_acc_nxt;
        r_avg_out <= w_acc_nxt[ACC_W-1:WIN_LOG2];
        r_max_out <= w_max_nxt;
        r_min_out <= w_min_nxt;
        r_cc_out  <= w_cc_nxt;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign acc       = r_acc_out;
  assign avg       = r_avg_out;
  assign max_val   = r_max_out;
  assign min_val   = r_min_out;
  assign carry_cnt = r_cc_out;

  // Running extremes are only observed through the next-value path.
  logic w_unused;
  assign w_unused = ^{w_max, w_min};

endmodule

// File: doc/adder8_result_accum.md
Name: adder8_result_accum

Overview:
- Downstream consumer of the 8-bit pipelined adder; captures each result {cout,sum} as a 9-bit sample.
- Reduces every window of 2**WIN_LOG2 valid samples to sum, truncated average, max, min and carry count.
- Publishes the window result with a one-cycle out_valid pulse.
- Sits between the adder pipeline output and the stats/monitor logic; input is sample-by-valid, with no backpressure.

Parameters:
- WIN_LOG2, 3, log2 of window length N (N = 8 by default); legal range 1..6.
- SMP_W, 9, sample width, {cout,sum}; fixed by the adder, not to be overridden.
- ACC_W, SMP_W+WIN_LOG2, accumulator width; sized so N*511 never overflows.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, active-low, synchronous.
- in_valid  in  1  adder result valid this cycle.
- cout  in  1  adder carry-out (sample bit 8).
- sum  in  8  adder sum (sample bits 7:0).
- clear  in  1  synchronous window abort/restart.
- out_valid  out  1  one-cycle pulse, window result valid.
- acc  out  ACC_W  sum of the N samples.
- avg  out  SMP_W  acc >> WIN_LOG2, truncated.
- max_val  out  SMP_W  largest sample in window.
- min_val  out  SMP_W  smallest sample in window.
- carry_cnt  out  WIN_LOG2+1  number of samples with cout=1.

Behaviour:
- Clocking/reset:
  - Single clock; all state updates on posedge clk.
  - Reset is synchronous and active-low: rst_n=0 sampled at a posedge clears everything.
  - Reset values: sample counter 0, running registers 0, out_valid 0, acc/avg/max_val/min_val/carry_cnt 0.
- Sample: v = {cout,sum}, unsigned 0..511; taken only when in_valid=1.
- Counter cnt (WIN_LOG2 bits) is the window state:
  - cnt=0: window empty.
  - cnt=k: k samples held.
- Accept with cnt=0:
  - run_acc<=v, run_max<=v, run_min<=v, run_cc<=cout.
  - This re-seeds the window; no stale compare from the previous window.
- Accept with cnt>0:
  - run_acc+=v; run_max<=max(run_max,v); run_min<=min(run_min,v); run_cc+=cout.
- Accept with cnt=N-1 (last sample):
  - Output registers load the final values including v, computed combinationally from running regs + v in the same cycle.
  - out_valid<=1 for exactly one cycle; cnt wraps to 0.
  - Latency: outputs are valid on the cycle after the Nth accepted sample.
- in_valid=0: no state change; gaps of any length are allowed inside a window.
- Back-to-back windows: a sample on the cycle that out_valid is high is sample 0 of the next window. No bubble is required.
- Output hold: acc/avg/max_val/min_val/carry_cnt hold the last completed window until the next completion. out_valid is 0 otherwise.
- clear=1:
  - cnt<=0; running registers are abandoned; outputs are untouched.
  - out_valid<=0 that cycle, even if the same cycle would have completed the window.
  - clear with in_valid=1: clear wins and the sample is discarded.
- Reset mid-window: partial window lost; first accepted sample after reset is sample 0.
- Arithmetic: all unsigned. Compares are 9-bit unsigned. carry_cnt max = N, hence WIN_LOG2+1 bits.
- No X propagation: sum/cout are ignored when in_valid=0.

Decomposition:
- Shared package adder8_pkg:
  - SMP_W=9, default WIN_LOG2=3.
  - Typedef for the 9-bit sample.
  - Function max9/min9.
- One natural sub-module: adder8_minmax.
  - Holds the running max/min registers with a seed/update/hold control.
  - Instantiated once.
- Counter, accumulator and output registers stay in the top.

Test Plan:
- Values 1..8, cout=0, in_valid every cycle, N=8 -> one cycle after the 8th sample: out_valid=1 for 1 cycle; acc=36, avg=4, max_val=8, min_val=1, carry_cnt=0.
- Eight samples of {cout=1,sum=0xFF} -> acc=4088, avg=511, max_val=511, min_val=511, carry_cnt=8; no overflow.
- Samples 300,5,5,5,5,5,5,5 with random in_valid gaps (1-4 idle cycles) -> acc=335, avg=41, max_val=300, min_val=5, carry_cnt=1 (only 300 has cout=1); out_valid only after the 8th valid sample.
- Two windows back-to-back (window A all 10, window B all 20) -> pulse A: acc=80, avg=10; pulse B exactly 8 cycles later: acc=160, avg=20; min_val=20 in B (seed, not 10).
- 5 samples, then clear together with a 6th valid sample, then 8 samples of 7 -> no pulse for the aborted window; next pulse: acc=56, min=max=7; previous outputs held until then.
- rst_n=0 for 1 cycle after 4 samples (prior window had completed) -> all outputs 0 next cycle, out_valid=0; the following 8 samples form a fresh window.
